stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- Val/rdy stream demultiplexer: one input stream is steered to one of p_nout output streams, chosen by a per-message select field.
- Each output has a single-entry pipe buffer, so the output side is registered: 1-cycle latency, full throughput.
- Used wherever one producer feeds several consumers, e.g. a response network or splitting per-bank requests. It performs the reverse of our N-input muxes.

Parameters:
- p_nbits, 32, message width in bits.
- p_nout, 4, number of output streams; legal range 2..8.
- c_sel_nbits, $clog2(p_nout), derived localparam for the select width; not overridable.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_val  input  1  input message valid.
- in_rdy  output  1  input ready.
- in_msg  input  p_nbits  input payload.
- in_sel  input  c_sel_nbits  destination index; meaningful only while in_val=1.
- out_val  output  p_nout  per-output valid; bit i belongs to output i.
- out_rdy  input  p_nout  per-output ready.
- out_msg  output  p_nout*p_nbits  flattened payloads; output i is bits [i*p_nbits +: p_nbits].
- err  output  1  sticky flag: at least one message was accepted with in_sel >= p_nout.

Behaviour:
- Reset (reset_n=0 sampled at a rising edge):
  - all buffers empty: out_val=0;
  - out_msg=0;
  - err=0.
  - Reset mid-operation discards all buffered messages; no partial transfer survives.
- Transfers: an input transfer occurs when in_val & in_rdy. Output i transfers when out_val[i] & out_rdy[i].
- Buffer i holds one message; out_val[i]=full[i], and out_msg slice i is driven from the buffer register.
- Ready for an in-range select: in_rdy = ~full[in_sel] | out_rdy[in_sel] (pipe behaviour).
  - in_rdy is combinational in in_sel, full and out_rdy. It must never depend on in_val.
  - There is no combinational path from in_msg to any output.
- Ready for an out-of-range select (in_sel >= p_nout, only possible when p_nout is not a power of 2): in_rdy=1.
  - The message is accepted and discarded.
  - err is set on the next edge and stays set until reset.
- Latency: a message accepted at edge t appears with out_val[in_sel]=1 from t to t+1. No output bypasses its buffer.
- Same-cycle dequeue and enqueue on the same port i: the buffer stays full, the new message replaces the old one, and throughput is 1 message/cycle/port.
- Dequeue on port i with an enqueue to port j≠i in the same cycle: the two are independent, and full[i] clears.
- Empty buffer: out_msg slice i holds its last value (0 after reset). Consumers must ignore it while out_val[i]=0.
- Back-pressure is head-of-line: if the selected port is blocked, in_rdy=0 even when other ports are empty.
- Message order per output is preserved. Across outputs no ordering is implied.
- out_rdy may toggle freely. Per the val/rdy contract, a held message must not change while out_val=1 and out_rdy=0.
- Misuse: X on in_sel while in_val=1 is an upstream protocol violation. The bench flags it with an assertion.

Decomposition:
- No shared package is needed. The select width is a local derived constant.
- One natural sub-module: stream_demux_buf, a single-entry pipe buffer with enq_val, enq_rdy, enq_msg, deq_val, deq_rdy, deq_msg, clk and reset_n.
  - The top instantiates p_nout copies in a generate loop.
  - The top adds one-hot decode of in_sel to enq_val, the in_rdy select, and the err register.

Test Plan:
- Reset, then steer in_sel=0..3 with msgs 0xA0..0xA3 (all out_rdy=1) -> each out_val[i] pulses exactly 1 cycle after its accept, carrying 0xA0+i; err stays 0.
- Stream 8 back-to-back msgs 0x10..0x17 to port 2 with out_rdy[2]=1 -> in_rdy=1 every cycle, port 2 emits 0x10..0x17 in order, 1/cycle.
- Hold out_rdy[1]=0, send 0x55 then 0x66 to port 1 -> 0x55 is held with out_val[1]=1 and in_rdy=0 for the second message. With in_sel=3 presented meanwhile, in_rdy=1 and port 3 receives 0x66's successor. Releasing out_rdy[1] lets 0x66 follow 0x55.
- p_nout=3: send in_sel=3 with msg 0xFF -> accepted (in_rdy=1), no out_val asserted, err=1 next cycle and still 1 after 10 more cycles.
- Fill ports 0 and 2 with out_rdy=0, then pull reset_n=0 for 1 cycle -> out_val=0, out_msg=0 and err=0 on the next edge. A new message to port 0 then arrives normally.
- Random test: random in_val, in_sel and out_rdy over 10k cycles against a per-port FIFO scoreboard -> no loss, no duplication, in-order delivery per port, and in_rdy never depends on in_val.

Source files
------------

// File: rtl/stream_demux_buf.sv
// Single-entry pipe buffer: accepts a new message in the same cycle the held
// one drains, so one port sustains one message per cycle with registered outputs.
module stream_demux_buf #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_nbits-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_nbits-1:0] deq_msg
);

    logic               full_q, full_d;
    logic [p_nbits-1:0] msg_q, msg_d;

    always_comb begin
        enq_rdy = ~full_q | deq_rdy;
        full_d  = full_q;
        msg_d   = msg_q;
        if (enq_val && enq_rdy) begin
            full_d = 1'b1;
            msg_d  = enq_msg;
        end else if (full_q && deq_rdy) begin
            full_d = 1'b0;
        end
    end

    // Payload is left untouched on dequeue; consumers qualify it with deq_val.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            msg_q  <= '0;
        end else begin
            full_q <= full_d;
            msg_q  <= msg_d;
        end
    end

    assign deq_val = full_q;
    assign deq_msg = msg_q;

endmodule

// File: rtl/stream_demux.sv
// Val/rdy demultiplexer: steers one input stream to one of p_nout buffered
// outputs by in_sel; out-of-range selects are swallowed and latch a sticky err.
module stream_demux #(
    parameter int p_nbits = 32,
    parameter int p_nout  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_val,
    output logic                       in_rdy,
    input  logic [p_nbits-1:0]         in_msg,
    input  logic [$clog2(p_nout)-1:0]  in_sel,
    output logic [p_nout-1:0]          out_val,
    input  logic [p_nout-1:0]          out_rdy,
    output logic [p_nout*p_nbits-1:0]  out_msg,
    output logic                       err
);

    localparam int c_sel_nbits = $clog2(p_nout);
    localparam int c_nslots    = 1 << c_sel_nbits;
    localparam logic [c_sel_nbits:0] c_nout = (c_sel_nbits+1)'(p_nout);

    logic [p_nout-1:0]   enq_val;
    logic [p_nout-1:0]   buf_rdy;
    logic [c_nslots-1:0] rdy_ext;
    logic                sel_ok;
    logic                err_q, err_d;

    assign sel_ok = ({1'b0, in_sel} < c_nout);

    // Unused select codes read as ready so bad messages drain instead of stalling.
    always_comb begin
        rdy_ext = '1;
        for (int i = 0; i < p_nout; i++) rdy_ext[i] = buf_rdy[i];
    end

    assign in_rdy = rdy_ext[in_sel];

    genvar gi;
    generate
        for (gi = 0; gi < p_nout; gi++) begin : g_port
            assign enq_val[gi] = in_val && (in_sel == c_sel_nbits'(gi));

            stream_demux_buf #(.p_nbits(p_nbits)) u_buf (
                .clk     (clk),
                .reset_n (reset_n),
                .enq_val (enq_val[gi]),
                .enq_rdy (buf_rdy[gi]),
                .enq_msg (in_msg),
                .deq_val (out_val[gi]),
                .deq_rdy (out_rdy[gi]),
                .deq_msg (out_msg[gi*p_nbits +: p_nbits])
            );
        end
    endgenerate

    always_comb begin
        err_d = err_q | (in_val & in_rdy & ~sel_ok);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign err = err_q;

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench: a 4-port instance under directed and random traffic plus a
// 3-port instance for the out-of-range select / sticky err path.
module tb_stream_demux;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_val, in_rdy;
    logic [31:0]  in_msg;
    logic [1:0]   in_sel;
    logic [3:0]   out_val, out_rdy;
    logic [127:0] out_msg;
    logic         err;

    logic         in_val3, in_rdy3;
    logic [31:0]  in_msg3;
    logic [1:0]   in_sel3;
    logic [2:0]   out_val3, out_rdy3;
    logic [95:0]  out_msg3;
    logic         err3;

    int nvec = 0;
    int nerr = 0;
    int ndeq[4];
    bit mon_en = 1'b0;
    logic [31:0] sbq[4][$];

    always #5 clk = ~clk;

    stream_demux #(.p_nbits(32), .p_nout(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg), .in_sel(in_sel),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .err(err)
    );

    stream_demux #(.p_nbits(32), .p_nout(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .in_val(in_val3), .in_rdy(in_rdy3), .in_msg(in_msg3), .in_sel(in_sel3),
        .out_val(out_val3), .out_rdy(out_rdy3), .out_msg(out_msg3), .err(err3)
    );

    always @(posedge clk) begin
        if (in_val === 1'b1 && $isunknown(in_sel))
            $error("in_sel unknown while in_val=1");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs are compared against the per-port queues, then the queues are
    // advanced for the transfers that the coming edge will commit.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("out_val[%0d]", i), 64'(out_val[i]), 64'(sbq[i].size() != 0));
                if (sbq[i].size() != 0)
                    chk($sformatf("out_msg[%0d]", i), 64'(out_msg[i*32 +: 32]), 64'(sbq[i][0]));
            end
            chk("err", 64'(err), 64'd0);
            if (reset_n) begin
                chk("in_rdy", 64'(in_rdy), 64'(sbq[in_sel].size() == 0 || out_rdy[in_sel]));
                for (int i = 0; i < 4; i++) begin
                    if (out_val[i] && out_rdy[i] && sbq[i].size() != 0) begin
                        void'(sbq[i].pop_front());
                        ndeq[i]++;
                    end
                end
                if (in_val && in_rdy) sbq[in_sel].push_back(in_msg);
            end else begin
                for (int i = 0; i < 4; i++) sbq[i].delete();
            end
        end
    end

    task automatic send(input logic [1:0] sel, input logic [31:0] msg);
        int n;
        in_val = 1'b1; in_sel = sel; in_msg = msg;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_rdy) break;
        end
        if (n == 50) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_val = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        logic r0;
        reset_n = 1'b0; in_val = 1'b0; in_sel = '0; in_msg = '0; out_rdy = '1;
        in_val3 = 1'b0; in_sel3 = '0; in_msg3 = '0; out_rdy3 = '1;
        for (int i = 0; i < 4; i++) ndeq[i] = 0;
        tick(2);
        reset_n = 1'b1;
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_out_msg", 64'(out_msg[63:0]), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        mon_en = 1'b1;

        // one message per port; exact latency checked by the monitor
        for (int i = 0; i < 4; i++) send(2'(i), 32'hA0 + 32'(i));
        tick(2);
        for (int i = 0; i < 4; i++) chk($sformatf("steer_cnt[%0d]", i), 64'(ndeq[i]), 64'd1);

        // back-to-back burst to port 2
        d0 = ndeq[2];
        in_val = 1'b1; in_sel = 2'd2;
        for (int k = 0; k < 8; k++) begin
            in_msg = 32'h10 + 32'(k);
            @(negedge clk);
            chk("burst_rdy", 64'(in_rdy), 64'd1);
            @(posedge clk); #1;
        end
        in_val = 1'b0;
        tick(2);
        chk("burst_cnt", 64'(ndeq[2] - d0), 64'd8);

        // head-of-line blocking on port 1, port 3 still reachable
        out_rdy = 4'b1101;
        send(2'd1, 32'h55);
        in_val = 1'b1; in_sel = 2'd1; in_msg = 32'h66;
        @(negedge clk);
        chk("hol_blocked", 64'(in_rdy), 64'd0);
        chk("hol_held_val", 64'(out_val[1]), 64'd1);
        chk("hol_held_msg", 64'(out_msg[63:32]), 64'h55);
        @(posedge clk); #1;
        in_val = 1'b0;
        send(2'd3, 32'h77);
        out_rdy = 4'b1111;
        send(2'd1, 32'h66);
        tick(2);
        chk("hol_port1_cnt", 64'(ndeq[1]), 64'd3);

        // p_nout=3: valid then out-of-range select
        in_val3 = 1'b1; in_sel3 = 2'd2; in_msg3 = 32'h33;
        #1 chk("d3_rdy_ok", 64'(in_rdy3), 64'd1);
        tick(1);
        in_val3 = 1'b0;
        chk("d3_val", 64'(out_val3), 64'b100);
        chk("d3_msg", 64'(out_msg3[95:64]), 64'h33);
        chk("d3_err_clear", 64'(err3), 64'd0);
        in_val3 = 1'b1; in_sel3 = 2'd3; in_msg3 = 32'hFF;
        #1 chk("d3_rdy_bad", 64'(in_rdy3), 64'd1);
        tick(1);
        in_val3 = 1'b0;
        chk("d3_no_val", 64'(out_val3), 64'd0);
        chk("d3_err_set", 64'(err3), 64'd1);
        tick(10);
        chk("d3_err_sticky", 64'(err3), 64'd1);

        // reset with ports 0 and 2 occupied
        out_rdy = 4'b1010;
        send(2'd0, 32'hC0);
        send(2'd2, 32'hC2);
        tick(1);
        chk("pre_rst_val", 64'(out_val), 64'b0101);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        chk("mid_rst_val", 64'(out_val), 64'd0);
        chk("mid_rst_msg", 64'(out_msg[95:0]), 64'd0);
        chk("mid_rst_err3", 64'(err3), 64'd0);
        out_rdy = 4'b1111;
        d0 = ndeq[0];
        send(2'd0, 32'hBEEF);
        tick(1);
        chk("post_rst_cnt", 64'(ndeq[0] - d0), 64'd1);

        // random traffic, with in_rdy probed against a flipped in_val
        for (int c = 0; c < 10000; c++) begin
            in_val  = 1'($urandom_range(0, 1));
            in_sel  = 2'($urandom_range(0, 3));
            in_msg  = $urandom;
            out_rdy = 4'($urandom);
            #1 r0 = in_rdy;
            in_val = ~in_val;
            #1 chk("rdy_vs_val", 64'(in_rdy), 64'(r0));
            in_val = ~in_val;
            @(posedge clk); #1;
        end
        in_val = 1'b0; out_rdy = '1;
        tick(3);
        for (int i = 0; i < 4; i++)
            chk($sformatf("drain[%0d]", i), 64'(sbq[i].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
